// File: rtl/key_uart_responder.sv
// key_uart_responder: bus slave buffering key codes in a FIFO, sending stores as 8N1 UART
// frames and raising the external interrupt while key data waits.
module key_uart_responder #(
   parameter logic [63:0] Key_base     = 64'h0000_0000_1000_0000,
   parameter logic [63:0] Art_base     = 64'h0000_0000_1000_0100,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] bus_address,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   input  logic [63:0] bus_write_data,
   output logic [63:0] bus_read_data,
   output logic [3:0]  interrupt_vector,
   input  logic        interrupt_ack,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic        uart_tx,
   output logic        tx_busy
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {IRQ_IDLE, IRQ_RAISED, IRQ_ACKED} irq_state_t;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [3:0]    count_q;
   logic          ovf_q, ovr_q;
   logic [63:0]   rdata_q, status;
   tx_state_t     tx_q, tx_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   irq_state_t    irq_q, irq_d;
   logic          rd_key, rd_stat, wr_art, empty, full, pop, push;
   assign rd_key  = bus_read_enable && bus_address == Key_base;
   assign rd_stat = bus_read_enable && bus_address == Key_base + 64'd8;
   assign wr_art  = bus_write_enable && bus_address == Art_base;
   assign empty   = count_q == 4'd0;
   assign full    = count_q == 4'(FIFO_DEPTH);
   assign pop     = rd_key && !empty;
   // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
   assign push    = key_valid && (!full || pop);
   assign tx_busy = tx_q != TX_IDLE;
   assign status  = {56'd0, count_q, ovr_q, ovf_q, tx_busy, !empty};
   assign bus_read_data    = rdata_q;
   assign interrupt_vector = irq_q == IRQ_RAISED ? 4'd1 : 4'd0;
   assign uart_tx = tx_q == TX_START ? 1'b0 : tx_q == TX_DATA ? shift_q[bit_q] : 1'b1;
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= key_code;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ovr_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + AW'(1);
         count_q <= count_q + 4'(push) - 4'(pop);
         ovf_q   <= (key_valid && !push) || (ovf_q && !rd_stat);
         ovr_q   <= (wr_art && tx_busy) || (ovr_q && !rd_stat);
         if (bus_read_enable)
            rdata_q <= pop ? {55'd0, 1'b1, mem_q[rd_ptr_q]} : rd_stat ? status : 64'd0;
      end
   end
   always_comb begin
      tx_d    = tx_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      if (tx_q == TX_IDLE) begin
         if (wr_art) begin
            tx_d    = TX_START;
            baud_d  = '0;
            bit_d   = 3'd0;
            shift_d = bus_write_data[7:0];
         end
      end else if (baud_q == CW'(CLKS_PER_BIT - 1)) begin
         baud_d = '0;
         bit_d  = tx_q == TX_DATA ? bit_q + 3'd1 : 3'd0;
         tx_d   = tx_q == TX_START ? TX_DATA :
                  tx_q == TX_STOP  ? TX_IDLE :
                  bit_q == 3'd7    ? TX_STOP : TX_DATA;
      end else begin
         baud_d = baud_q + CW'(1);
      end
   end
   always_comb begin
      irq_d = irq_q == IRQ_IDLE   ? (empty ? IRQ_IDLE : IRQ_RAISED) :
              irq_q == IRQ_RAISED ? (interrupt_ack ? IRQ_ACKED : IRQ_RAISED) :
              rd_key              ? IRQ_IDLE : IRQ_ACKED;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q    <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         irq_q   <= IRQ_IDLE;
      end else begin
         tx_q    <= tx_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         irq_q   <= irq_d;
      end
   end
endmodule

// File: tb/tb_key_uart_responder.sv
// tb_key_uart_responder: randomized bench against a queue-based model of the key FIFO,
// sticky flags, read-data register and UART busy window.
module tb_key_uart_responder;
   localparam int C = 4;
   localparam int D = 8;
   localparam logic [63:0] KEY  = 64'h0000_0000_1000_0000;
   localparam logic [63:0] STAT = 64'h0000_0000_1000_0008;
   localparam logic [63:0] ART  = 64'h0000_0000_1000_0100;
   localparam logic [63:0] UNM  = 64'h0000_0000_1000_0004;
   logic        clk = 1'b0, reset = 1'b1;
   logic [63:0] bus_address = '0, bus_write_data = '0, bus_read_data;
   logic        bus_read_enable = 1'b0, bus_write_enable = 1'b0;
   logic [3:0]  interrupt_vector;
   logic        interrupt_ack = 1'b0, key_valid = 1'b0, uart_tx, tx_busy;
   logic [7:0]  key_code = '0;
   int total = 0, bad = 0;
   logic [7:0]  mq[$];
   bit          m_ovf, m_ovr;
   int          m_left;
   logic [63:0] m_rd;

   key_uart_responder #(.Key_base(KEY), .Art_base(ART), .FIFO_DEPTH(D), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .bus_address(bus_address), .bus_read_enable(bus_read_enable),
      .bus_write_enable(bus_write_enable), .bus_write_data(bus_write_data),
      .bus_read_data(bus_read_data), .interrupt_vector(interrupt_vector),
      .interrupt_ack(interrupt_ack), .key_valid(key_valid), .key_code(key_code),
      .uart_tx(uart_tx), .tx_busy(tx_busy));

   always #5 clk = ~clk;

   function automatic logic [63:0] m_status();
      return {56'd0, 4'(mq.size()), m_ovr, m_ovf, m_left != 0, mq.size() != 0};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0;
      m_ovr = 0;
      m_left = 0;
      m_rd = '0;
   endtask

   // One clock edge of stimulus; the model advances by the same edge and exp is the
   // read-data register value the DUT must show afterwards.
   task automatic step(input bit kv, input logic [7:0] kc, input bit re, input logic [63:0] ra,
                       input bit we, input logic [63:0] wa, input logic [7:0] wd,
                       output logic [63:0] exp);
      bit busy, pop, rs, ovf_ev, art;
      busy = m_left != 0;
      pop  = re && ra == KEY && mq.size() != 0;
      rs   = re && ra == STAT;
      art  = we && wa == ART;
      if (re) m_rd = pop ? {55'd0, 1'b1, mq[0]} : rs ? m_status() : 64'd0;
      if (pop) void'(mq.pop_front());
      ovf_ev = kv && mq.size() == D;
      if (kv && mq.size() < D) mq.push_back(kc);
      m_ovf  = ovf_ev || (m_ovf && !rs);
      m_ovr  = (art && busy) || (m_ovr && !rs);
      m_left = (art && !busy) ? 10 * C : busy ? m_left - 1 : 0;
      exp = m_rd;
      key_valid = kv;
      key_code = kc;
      bus_read_enable = re;
      bus_address = re ? ra : wa;
      bus_write_enable = we;
      bus_write_data = {56'd0, wd};
      if (re && we && ra != wa) $display("note: bench drives one address per edge");
      @(posedge clk);
      #1;
      key_valid = 0;
      bus_read_enable = 0;
      bus_write_enable = 0;
      interrupt_ack = 0;
   endtask

   task automatic idle(input int n);
      logic [63:0] e;
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 64'd0, 0, 64'd0, 8'h00, e);
   endtask

   task automatic rd(input logic [63:0] a, output logic [63:0] e);
      step(0, 8'h00, 1, a, 0, 64'd0, 8'h00, e);
   endtask

   task automatic push(input logic [7:0] c);
      logic [63:0] e;
      step(1, c, 0, 64'd0, 0, 64'd0, 8'h00, e);
   endtask

   task automatic wr_art(input logic [7:0] d);
      logic [63:0] e;
      step(0, 8'h00, 0, 64'd0, 1, ART, d, e);
   endtask

   task automatic test_reset();
      logic [63:0] e;
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      idle(20);
      total++; if (bus_read_data !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus_read_data); end
      total++; if (interrupt_vector !== 4'd0) begin bad++; $display("FAIL reset_vec got=%h exp=0", interrupt_vector); end
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
      rd(STAT, e);
      total++; if (bus_read_data !== e || e !== 64'd0) begin bad++; $display("FAIL reset_status got=%h exp=%h", bus_read_data, e); end
   endtask

   task automatic test_interrupt();
      logic [63:0] e;
      push(8'h41);
      total++; if (interrupt_vector !== 4'd0) begin bad++; $display("FAIL irq_early got=%h exp=0", interrupt_vector); end
      idle(1);
      total++; if (interrupt_vector !== 4'd1) begin bad++; $display("FAIL irq_raise got=%h exp=1", interrupt_vector); end
      interrupt_ack = 1;
      idle(1);
      total++; if (interrupt_vector !== 4'd0) begin bad++; $display("FAIL irq_ack got=%h exp=0", interrupt_vector); end
      rd(KEY, e);
      total++; if (bus_read_data !== e || e !== 64'h141) begin bad++; $display("FAIL irq_keyread got=%h exp=%h", bus_read_data, e); end
      idle(2);
      total++; if (interrupt_vector !== 4'd0) begin bad++; $display("FAIL irq_stays_low got=%h exp=0", interrupt_vector); end
      rd(STAT, e);
      total++; if (bus_read_data !== e) begin bad++; $display("FAIL irq_status got=%h exp=%h", bus_read_data, e); end
      push(8'h22);
      interrupt_ack = 1;
      idle(1);
      total++; if (interrupt_vector !== 4'd1) begin bad++; $display("FAIL irq_ack_outside got=%h exp=1", interrupt_vector); end
      interrupt_ack = 1;
      idle(1);
      push(8'h23);
      rd(KEY, e);
      total++; if (interrupt_vector !== 4'd0) begin bad++; $display("FAIL irq_acked_read got=%h exp=0", interrupt_vector); end
      idle(1);
      total++; if (interrupt_vector !== 4'd1) begin bad++; $display("FAIL irq_reraise got=%h exp=1", interrupt_vector); end
      rd(KEY, e);
      total++; if (bus_read_data !== e) begin bad++; $display("FAIL irq_drain got=%h exp=%h", bus_read_data, e); end
   endtask

   task automatic test_overflow();
      logic [63:0] e;
      for (int i = 1; i <= 9; i++) push(8'(i));
      rd(STAT, e);
      total++; if (bus_read_data !== e || e !== 64'h85) begin bad++; $display("FAIL ovf_status1 got=%h exp=%h", bus_read_data, e); end
      rd(STAT, e);
      total++; if (bus_read_data !== e || e !== 64'h81) begin bad++; $display("FAIL ovf_status2 got=%h exp=%h", bus_read_data, e); end
      for (int i = 1; i <= 9; i++) begin
         rd(KEY, e);
         total++; if (bus_read_data !== e) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus_read_data, e); end
      end
   endtask

   task automatic test_full_push_pop();
      logic [63:0] e;
      for (int i = 0; i < D; i++) push(8'($urandom));
      step(1, 8'hEE, 1, KEY, 0, 64'd0, 8'h00, e);
      total++; if (bus_read_data !== e) begin bad++; $display("FAIL full_pp_read got=%h exp=%h", bus_read_data, e); end
      rd(STAT, e);
      total++; if (bus_read_data !== e || e !== 64'h81) begin bad++; $display("FAIL full_pp_status got=%h exp=%h", bus_read_data, e); end
      for (int i = 0; i < D; i++) begin
         rd(KEY, e);
         total++; if (bus_read_data !== e) begin bad++; $display("FAIL full_pp_drain%0d got=%h exp=%h", i, bus_read_data, e); end
      end
   endtask

   task automatic test_random();
      logic [63:0] e, a;
      bit kv, re, we;
      for (int i = 0; i < 400; i++) begin
         kv = $urandom_range(0, 2) == 0;
         re = $urandom_range(0, 1) == 1;
         we = !re && $urandom_range(0, 11) == 0;
         case ($urandom_range(0, 3))
            0, 1: a = KEY;
            2: a = STAT;
            default: a = UNM;
         endcase
         step(kv, 8'($urandom), re, a, we, $urandom_range(0, 5) == 0 ? UNM : ART, 8'($urandom), e);
         total++; if (bus_read_data !== e) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, bus_read_data, e); end
         total++; if (tx_busy !== (m_left != 0)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, tx_busy, m_left != 0); end
      end
      while (mq.size() != 0) rd(KEY, e);
      rd(STAT, e);
   endtask

   task automatic test_uart();
      logic [9:0] fr;
      int busy_cnt;
      fr = {1'b1, 8'hA5, 1'b0};
      busy_cnt = 0;
      while (m_left != 0) idle(1);
      wr_art(8'hA5);
      for (int k = 0; k < 10 * C; k++) begin
         total++; if (uart_tx !== fr[k / C]) begin bad++; $display("FAIL uart_bit k=%0d got=%b exp=%b", k, uart_tx, fr[k / C]); end
         if (tx_busy === 1'b1) busy_cnt++;
         idle(1);
      end
      total++; if (busy_cnt != 10 * C || tx_busy !== 1'b0) begin bad++; $display("FAIL uart_busy_len got=%0d/%b exp=%0d/0", busy_cnt, tx_busy, 10 * C); end
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL uart_idle got=%b exp=1", uart_tx); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e;
      logic [7:0] got;
      got = '0;
      wr_art(8'h3C);
      for (int k = 0; k < 10 * C; k++) begin
         if (k % C == 2 && k / C >= 1 && k / C <= 8) got[k / C - 1] = uart_tx;
         if (k == 5) wr_art(8'hFF);
         else idle(1);
      end
      total++; if (got !== 8'h3C) begin bad++; $display("FAIL b2b_byte got=%h exp=3c", got); end
      wr_art(8'h81);
      wr_art(8'h00);
      rd(STAT, e);
      total++; if (bus_read_data !== e || e[3] !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%h exp=%h", bus_read_data, e); end
      rd(STAT, e);
      total++; if (bus_read_data !== e) begin bad++; $display("FAIL b2b_clear got=%h exp=%h", bus_read_data, e); end
      idle(3);
      #2 reset = 1;
      #1;
      total++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL midframe_reset got=%b/%b exp=1/0", uart_tx, tx_busy); end
      total++; if (bus_read_data !== 64'd0) begin bad++; $display("FAIL midframe_rdata got=%h exp=0", bus_read_data); end
      model_reset();
      @(posedge clk);
      #1 reset = 0;
      idle(2);
      total++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL post_reset got=%b/%b exp=1/0", uart_tx, tx_busy); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_interrupt();
      test_overflow();
      test_full_push_pop();
      test_random();
      test_uart();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
